// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: per-stage hold/bubble and PC write enable, load-use stalls,
// EX redirects, LM/SM micro-sequencing and saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int NUM_PR = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rr_valid,
  input  logic [2:0]        rr_src_a,
  input  logic              rr_use_a,
  input  logic [2:0]        rr_src_b,
  input  logic              rr_use_b,
  input  logic              rr_is_multi,
  input  logic [7:0]        rr_mask,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic              ex_wr,
  input  logic [2:0]        ex_dst,
  input  logic              ex_redirect,
  output logic              pc_write,
  output logic [NUM_PR-1:0] pr_hold,
  output logic [NUM_PR-1:0] pr_bubble,
  output logic              multi_busy,
  output logic [2:0]        multi_reg,
  output logic              multi_last,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic {RUN, MULTI} state_t;

  state_t           state_reg, state_next;
  logic [7:0]       mask_reg, mask_next;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;
  logic             hz, enter_multi, stall_evt;
  logic [7:0]       cur_mask, rest_mask;
  logic [2:0]       low_idx;

  assign hz = rr_valid & ex_valid & ex_is_load & ex_wr &
              ((rr_use_a & (rr_src_a == ex_dst)) | (rr_use_b & (rr_src_b == ex_dst)));

  assign enter_multi = (state_reg == RUN) & rr_valid & rr_is_multi & (|rr_mask) &
                       ~hz & ~ex_redirect;

  assign stall_evt = (state_reg == RUN) & hz & ~ex_redirect;

  // On the entry cycle the first transfer comes straight from the RR mask.
  assign cur_mask  = (state_reg == MULTI) ? mask_reg : rr_mask;
  assign rest_mask = cur_mask & (cur_mask - 8'd1);

  always_comb begin
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (cur_mask[i]) low_idx = 3'(i);
    end
  end

  always_comb begin
    pc_write   = 1'b1;
    pr_hold    = '0;
    pr_bubble  = '0;
    multi_busy = 1'b0;
    multi_reg  = 3'd0;
    multi_last = 1'b0;
    state_next = state_reg;
    mask_next  = mask_reg;
    if (reset) begin
      pc_write   = 1'b0;
      pr_bubble  = '1;
      state_next = RUN;
      mask_next  = 8'd0;
    end else if (ex_redirect) begin
      pr_bubble[2:0] = 3'b111;
      state_next     = RUN;
      mask_next      = 8'd0;
    end else if ((state_reg == MULTI) || enter_multi) begin
      multi_busy = 1'b1;
      multi_reg  = low_idx;
      if (rest_mask != 8'd0) begin
        pc_write     = 1'b0;
        pr_hold[1:0] = 2'b11;
        state_next   = MULTI;
        mask_next    = rest_mask;
      end else begin
        multi_last = 1'b1;
        state_next = RUN;
        mask_next  = 8'd0;
      end
    end else if (hz) begin
      pc_write     = 1'b0;
      pr_hold[1:0] = 2'b11;
      pr_bubble[2] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= RUN;
      mask_reg      <= 8'd0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      mask_reg  <= mask_next;
      if (stall_evt && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (ex_redirect && (flush_cnt_reg != '1)) flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, random stimulus against a
// queue-based reference model, and counter saturation with a 4-bit counter.
module tb_pipe_hazard_ctrl;
  localparam int NUM_PR = 6;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rr_valid = 0, rr_use_a = 0, rr_use_b = 0, rr_is_multi = 0;
  logic [2:0] rr_src_a = 0, rr_src_b = 0, ex_dst = 0;
  logic [7:0] rr_mask = 0;
  logic ex_valid = 0, ex_is_load = 0, ex_wr = 0, ex_redirect = 0;
  logic pc_write, multi_busy, multi_last;
  logic [NUM_PR-1:0] pr_hold, pr_bubble;
  logic [2:0] multi_reg;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.NUM_PR(NUM_PR), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .rr_valid(rr_valid), .rr_src_a(rr_src_a), .rr_use_a(rr_use_a),
    .rr_src_b(rr_src_b), .rr_use_b(rr_use_b), .rr_is_multi(rr_is_multi),
    .rr_mask(rr_mask), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
    .ex_wr(ex_wr), .ex_dst(ex_dst), .ex_redirect(ex_redirect),
    .pc_write(pc_write), .pr_hold(pr_hold), .pr_bubble(pr_bubble),
    .multi_busy(multi_busy), .multi_reg(multi_reg), .multi_last(multi_last),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic       rst, rrv;
    logic [2:0] sa;
    logic       ua;
    logic [2:0] sb;
    logic       ub, mul;
    logic [7:0] mask;
    logic       exv, ld, wr;
    logic [2:0] dst;
    logic       rd;
    logic       e_pc;
    logic [5:0] e_hold, e_bub;
    logic       e_busy;
    logic [2:0] e_reg;
    logic       e_last;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int pend[$];          // register indices still to transfer for the current LM/SM
  int m_stall = 0;
  int m_flush = 0;
  vec_t tbl[$];

  function automatic vec_t v(logic rst, logic rrv, logic [2:0] sa, logic ua, logic [2:0] sb,
                             logic ub, logic mul, logic [7:0] mask, logic exv, logic ld,
                             logic wr, logic [2:0] dst, logic rd, logic e_pc,
                             logic [5:0] e_hold, logic [5:0] e_bub, logic e_busy,
                             logic [2:0] e_reg, logic e_last);
    vec_t r;
    r = '{rst, rrv, sa, ua, sb, ub, mul, mask, exv, ld, wr, dst, rd,
          e_pc, e_hold, e_bub, e_busy, e_reg, e_last};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hz_now();
    return rr_valid && ex_valid && ex_is_load && ex_wr &&
           ((rr_use_a && rr_src_a == ex_dst) || (rr_use_b && rr_src_b == ex_dst));
  endfunction

  task automatic model_eval(output logic pc, output logic [5:0] hold, output logic [5:0] bub,
                            output logic busy, output logic [2:0] rg, output logic last);
    int lst[$];
    pc = 1; hold = 0; bub = 0; busy = 0; rg = 0; last = 0;
    if (reset) begin
      pc = 0; bub = 6'h3F;
    end else if (ex_redirect) begin
      bub = 6'h07;
    end else begin
      lst = pend;
      if (lst.size() == 0) begin
        if (hz_now()) begin
          pc = 0; hold = 6'h03; bub = 6'h04;
        end else if (rr_valid && rr_is_multi) begin
          for (int i = 0; i < 8; i++) if (rr_mask[i]) lst.push_back(i);
        end
      end
      if (lst.size() > 0) begin
        busy = 1; rg = 3'(lst[0]); last = (lst.size() == 1);
        pc = last; hold = last ? 6'h00 : 6'h03;
      end
    end
  endtask

  task automatic model_update();
    if (reset) begin
      pend.delete(); m_stall = 0; m_flush = 0;
    end else if (ex_redirect) begin
      pend.delete();
      if (m_flush < (1 << CNT_W) - 1) m_flush++;
    end else if (pend.size() == 0 && hz_now()) begin
      if (m_stall < (1 << CNT_W) - 1) m_stall++;
    end else begin
      if (pend.size() == 0 && rr_valid && rr_is_multi)
        for (int i = 0; i < 8; i++) if (rr_mask[i]) pend.push_back(i);
      if (pend.size() > 0) void'(pend.pop_front());
    end
  endtask

  // Drive one cycle of inputs, compare outputs (against the table or the model), advance model.
  task automatic step(input vec_t x, input bit use_tbl, input int idx);
    logic pc, busy, last;
    logic [5:0] hold, bub;
    logic [2:0] rg;
    @(negedge clk);
    reset = x.rst; rr_valid = x.rrv; rr_src_a = x.sa; rr_use_a = x.ua;
    rr_src_b = x.sb; rr_use_b = x.ub; rr_is_multi = x.mul; rr_mask = x.mask;
    ex_valid = x.exv; ex_is_load = x.ld; ex_wr = x.wr; ex_dst = x.dst; ex_redirect = x.rd;
    #2;
    if (use_tbl) begin
      pc = x.e_pc; hold = x.e_hold; bub = x.e_bub; busy = x.e_busy; rg = x.e_reg; last = x.e_last;
    end else begin
      model_eval(pc, hold, bub, busy, rg, last);
    end
    chk($sformatf("pc_write[%0d]", idx), 32'(pc_write), 32'(pc));
    chk($sformatf("pr_hold[%0d]", idx), 32'(pr_hold), 32'(hold));
    chk($sformatf("pr_bubble[%0d]", idx), 32'(pr_bubble), 32'(bub));
    chk($sformatf("multi_busy[%0d]", idx), 32'(multi_busy), 32'(busy));
    chk($sformatf("multi_reg[%0d]", idx), 32'(multi_reg), 32'(rg));
    chk($sformatf("multi_last[%0d]", idx), 32'(multi_last), 32'(last));
    chk($sformatf("stall_cnt[%0d]", idx), 32'(stall_cnt), 32'(m_stall));
    chk($sformatf("flush_cnt[%0d]", idx), 32'(flush_cnt), 32'(m_flush));
    $display("[TB] step %0d rst=%0b rd=%0b mask=%02h pc=%0b hold=%02h bub=%02h busy=%0b reg=%0d last=%0b",
             idx, reset, ex_redirect, rr_mask, pc_write, pr_hold, pr_bubble, multi_busy,
             multi_reg, multi_last);
    model_update();
  endtask

  initial begin
    vec_t x;
    //            rst rrv sa ua sb ub mul mask  exv ld wr dst rd | pc hold   bub    busy reg last
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0,   0, 6'h00, 6'h3F, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0,   0, 6'h00, 6'h3F, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0,   1, 6'h00, 6'h00, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 3, 1, 0, 8'h00, 1, 1, 1, 3, 0,   0, 6'h03, 6'h04, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 3, 1, 0, 8'h00, 0, 0, 0, 0, 0,   1, 6'h00, 6'h00, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 3, 0, 0, 8'h00, 1, 1, 1, 3, 0,   1, 6'h00, 6'h00, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 1, 8'hA4, 0, 0, 0, 0, 0,   0, 6'h03, 6'h00, 1, 2, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 1, 8'hA4, 0, 0, 0, 0, 0,   0, 6'h03, 6'h00, 1, 5, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 1, 8'hA4, 0, 0, 0, 0, 0,   1, 6'h00, 6'h00, 1, 7, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0,   1, 6'h00, 6'h00, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 1, 8'hFF, 0, 0, 0, 0, 0,   0, 6'h03, 6'h00, 1, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 1, 8'hFF, 0, 0, 0, 0, 1,   1, 6'h00, 6'h07, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0,   1, 6'h00, 6'h00, 0, 0, 0));
    tbl.push_back(v(0, 1, 3, 1, 0, 0, 0, 8'h00, 1, 1, 1, 3, 1,   1, 6'h00, 6'h07, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0,   1, 6'h00, 6'h00, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 0,   1, 6'h00, 6'h00, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 1, 8'h80, 0, 0, 0, 0, 0,   1, 6'h00, 6'h00, 1, 7, 1));
    tbl.push_back(v(0, 1, 2, 1, 0, 0, 1, 8'h03, 1, 1, 1, 2, 0,   0, 6'h03, 6'h04, 0, 0, 0));
    tbl.push_back(v(0, 1, 2, 1, 0, 0, 1, 8'h03, 0, 0, 0, 0, 0,   0, 6'h03, 6'h00, 1, 0, 0));
    tbl.push_back(v(0, 1, 2, 1, 0, 0, 1, 8'h03, 1, 1, 1, 2, 0,   1, 6'h00, 6'h00, 1, 1, 1));
    tbl.push_back(v(0, 1, 3, 1, 0, 0, 0, 8'h00, 1, 1, 0, 3, 0,   1, 6'h00, 6'h00, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1, i);
    chk("tbl_stall_total", 32'(stall_cnt), 32'd2);
    chk("tbl_flush_total", 32'(flush_cnt), 32'd2);

    for (int i = 0; i < 400; i++) begin
      x = '0;
      x.rst  = ($urandom_range(0, 39) == 0);
      x.rrv  = ($urandom_range(0, 3) != 0);
      x.sa   = 3'($urandom_range(0, 3));
      x.ua   = 1'($urandom);
      x.sb   = 3'($urandom_range(0, 3));
      x.ub   = 1'($urandom);
      x.mul  = ($urandom_range(0, 3) == 0);
      x.mask = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      x.exv  = 1'($urandom);
      x.ld   = 1'($urandom);
      x.wr   = ($urandom_range(0, 3) != 0);
      x.dst  = 3'($urandom_range(0, 3));
      x.rd   = ($urandom_range(0, 9) == 0);
      step(x, 1'b0, 1000 + i);
    end

    x = '0;
    x.rst = 1'b1;
    step(x, 1'b0, 2000);
    x = '0;
    x.rrv = 1; x.sa = 3'd1; x.ua = 1; x.exv = 1; x.ld = 1; x.wr = 1; x.dst = 3'd1;
    for (int i = 0; i < 14; i++) step(x, 1'b0, 2001 + i);
    x = '0;
    step(x, 1'b0, 2015);
    chk("stall_cnt_14", 32'(stall_cnt), 32'd14);
    x.rrv = 1; x.sa = 3'd1; x.ua = 1; x.exv = 1; x.ld = 1; x.wr = 1; x.dst = 3'd1;
    for (int i = 0; i < 6; i++) step(x, 1'b0, 2016 + i);
    x = '0;
    step(x, 1'b0, 2022);
    chk("stall_cnt_sat", 32'(stall_cnt), 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
